// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response signals and data-RAM bus of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment (decode stage plus RAM).
interface mem_access_unit_if;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        stall_request;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned_error;
  logic        bus_error;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;

  modport master (
    output mem_read_flag, mem_write_flag, mem_sign_flag, mem_sel, mem_addr, mem_write_data,
           ram_read_data, ram_ready,
    input  stall_request, load_data, load_valid, misaligned_error, bus_error,
           ram_en, ram_write_en, ram_addr, ram_write_data
  );

  modport slave (
    input  mem_read_flag, mem_write_flag, mem_sign_flag, mem_sel, mem_addr, mem_write_data,
           ram_read_data, ram_ready,
    output stall_request, load_data, load_valid, misaligned_error, bus_error,
           ram_en, ram_write_en, ram_addr, ram_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one aligned access, drives the data-RAM bus until ram_ready
// or a WAIT_LIMIT-cycle timeout, then returns the aligned and extended load result.
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] SEL_BYTE  = 4'b0001;
  localparam logic [3:0] SEL_HALF  = 4'b0011;
  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [3:0]  sel_q;
  logic        sign_q, write_q, timeout_q;
  logic [7:0]  wait_cnt_q;
  logic        req, misaligned, accept, wait_expired;

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [3:0] sel, input logic sign);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = word >> {off, 3'b000};
    half    = off[1] ? word[31:16] : word[15:0];
    if (sel == SEL_BYTE)      return {{24{sign & shifted[7]}}, shifted[7:0]};
    else if (sel == SEL_HALF) return {{16{sign & half[15]}}, half};
    else                      return word;
  endfunction

  // Request decode is combinational, so it is masked by reset to keep every strobe low in reset.
  assign req          = rst_n && (bus.mem_read_flag || bus.mem_write_flag);
  assign misaligned   = ((bus.mem_sel == SEL_HALF) && bus.mem_addr[0]) ||
                        ((bus.mem_sel != SEL_BYTE) && (bus.mem_sel != SEL_HALF) &&
                         (bus.mem_addr[1:0] != 2'b00));
  assign accept       = (state_q == IDLE) && req && !misaligned;
  assign wait_expired = (state_q == WAIT) && !bus.ram_ready && (wait_cnt_q == LAST_WAIT);

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (bus.ram_ready || wait_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_write_data = wdata_q;
    case (sel_q)
      SEL_BYTE: bus.ram_write_data = {4{wdata_q[7:0]}};
      SEL_HALF: bus.ram_write_data = {2{wdata_q[15:0]}};
      default:  bus.ram_write_data = wdata_q;
    endcase
  end

  assign bus.stall_request    = accept || (state_q == WAIT);
  assign bus.misaligned_error = (state_q == IDLE) && req && misaligned;
  assign bus.ram_en           = (state_q == WAIT);
  assign bus.ram_addr         = {addr_q[31:2], 2'b00};
  assign bus.ram_write_en     = ((state_q == WAIT) && write_q) ? (sel_q << addr_q[1:0]) : 4'b0000;
  assign bus.load_valid       = (state_q == DONE) && !write_q;
  assign bus.bus_error        = (state_q == DONE) && timeout_q;
  assign bus.load_data        = load_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      sign_q      <= 1'b0;
      write_q     <= 1'b0;
      timeout_q   <= 1'b0;
      wait_cnt_q  <= '0;
      load_data_q <= '0;
    end else if (accept) begin
      // Both flags set means a store.
      addr_q     <= bus.mem_addr;
      wdata_q    <= bus.mem_write_data;
      sel_q      <= bus.mem_sel;
      sign_q     <= bus.mem_sign_flag;
      write_q    <= bus.mem_write_flag;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      if (state_d == DONE) begin
        timeout_q <= wait_expired;
        if (!write_q)
          load_data_q <= extract_load(bus.ram_ready ? bus.ram_read_data : 32'h0,
                                      addr_q[1:0], sel_q, sign_q);
      end else begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares whenever the unit raises a strobe.
module tb_mem_access_unit;

  localparam int unsigned LIMIT = 4;
  localparam logic [31:0] JUNK  = 32'h5A5A_5A5A;

  typedef struct {
    logic        lv;
    logic        be;
    logic        me;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.WAIT_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus_if.load_valid || bus_if.bus_error || bus_if.misaligned_error)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected strobe: got lv=%0b be=%0b me=%0b expected none",
                 bus_if.load_valid, bus_if.bus_error, bus_if.misaligned_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe load_valid", 32'(bus_if.load_valid), 32'(mon_e.lv));
        check("strobe bus_error", 32'(bus_if.bus_error), 32'(mon_e.be));
        check("strobe misaligned_error", 32'(bus_if.misaligned_error), 32'(mon_e.me));
        if (mon_e.lv) check("strobe load_data", bus_if.load_data, mon_e.data);
      end
    end
  end

  task automatic clear_req();
    bus_if.mem_read_flag  = 1'b0;
    bus_if.mem_write_flag = 1'b0;
    bus_if.mem_sign_flag  = 1'b0;
    bus_if.mem_sel        = 4'b0000;
    bus_if.mem_addr       = 32'h0;
    bus_if.mem_write_data = 32'h0;
  endtask

  // lat = index of the WAIT cycle carrying ram_ready; lat >= LIMIT means ram_ready never comes.
  task automatic do_access(input string name, input logic rd, input logic wr, input logic sgn,
                           input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int lat, input logic [3:0] exp_we,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld, input logic exp_mis);
    exp_t e;
    int   n_wait;
    logic timeout;
    timeout = (lat >= int'(LIMIT));
    @(posedge clk); #1;
    bus_if.mem_read_flag  = rd;
    bus_if.mem_write_flag = wr;
    bus_if.mem_sign_flag  = sgn;
    bus_if.mem_sel        = sel;
    bus_if.mem_addr       = addr;
    bus_if.mem_write_data = wdata;
    bus_if.ram_ready      = 1'b0;
    bus_if.ram_read_data  = JUNK;
    if (exp_mis) begin
      e = '{lv: 1'b0, be: 1'b0, me: 1'b1, data: 32'h0};
      exp_q.push_back(e);
    end else if (rd && !wr) begin
      e = '{lv: 1'b1, be: timeout, me: 1'b0, data: exp_ld};
      exp_q.push_back(e);
    end
    @(negedge clk);
    check({name, " accept stall"}, 32'(bus_if.stall_request), 32'(!exp_mis));
    check({name, " accept ram_en"}, 32'(bus_if.ram_en), 32'h0);
    @(posedge clk); #1;
    clear_req();
    if (exp_mis) begin
      @(negedge clk);
      check({name, " after misaligned ram_en"}, 32'(bus_if.ram_en), 32'h0);
      check({name, " after misaligned stall"}, 32'(bus_if.stall_request), 32'h0);
      return;
    end
    n_wait = timeout ? int'(LIMIT) : lat + 1;
    for (int w = 0; w < n_wait; w++) begin
      bus_if.ram_ready     = (w == lat);
      bus_if.ram_read_data = (w == lat) ? rdata : JUNK;
      @(negedge clk);
      check({name, " wait ram_en"}, 32'(bus_if.ram_en), 32'h1);
      check({name, " wait stall"}, 32'(bus_if.stall_request), 32'h1);
      check({name, " ram_addr"}, bus_if.ram_addr, {addr[31:2], 2'b00});
      check({name, " ram_write_en"}, 32'(bus_if.ram_write_en), 32'(exp_we));
      if (wr) check({name, " ram_write_data"}, bus_if.ram_write_data, exp_wd);
      @(posedge clk); #1;
    end
    bus_if.ram_ready     = 1'b0;
    bus_if.ram_read_data = JUNK;
    @(negedge clk);
    check({name, " done ram_en"}, 32'(bus_if.ram_en), 32'h0);
    check({name, " done stall"}, 32'(bus_if.stall_request), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_req();
    bus_if.ram_ready     = 1'b0;
    bus_if.ram_read_data = JUNK;
    #12;
    check("reset stall", 32'(bus_if.stall_request), 32'h0);
    check("reset load_valid", 32'(bus_if.load_valid), 32'h0);
    check("reset misaligned", 32'(bus_if.misaligned_error), 32'h0);
    check("reset bus_error", 32'(bus_if.bus_error), 32'h0);
    check("reset ram_en", 32'(bus_if.ram_en), 32'h0);
    check("reset ram_write_en", 32'(bus_if.ram_write_en), 32'h0);
    check("reset ram_addr", bus_if.ram_addr, 32'h0);
    check("reset ram_write_data", bus_if.ram_write_data, 32'h0);
    check("reset load_data", bus_if.load_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //          name    rd    wr    sgn   sel      addr          wdata         rdata         lat we       wd            load result   mis
    do_access("LB",   1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
    do_access("LBU",  1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0);
    do_access("LH",   1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_0006, 32'h0,        32'h9ABC_1234, 2, 4'b0000, 32'h0,        32'hFFFF_9ABC, 1'b0);
    do_access("LHU",  1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000_0004, 32'h0,        32'h9ABC_8001, 0, 4'b0000, 32'h0,        32'h0000_8001, 1'b0);
    do_access("LB+",  1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_0021, 32'h0,        32'h1122_7F44, 0, 4'b0000, 32'h0,        32'h0000_007F, 1'b0);
    do_access("LW",   1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0);
    do_access("SH",   1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0202, 32'h1234_ABCD, JUNK,         2, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
    check("load_data held after store", bus_if.load_data, 32'hCAFE_F00D);
    do_access("SB rw", 1'b1, 1'b1, 1'b0, 4'b0001, 32'h0000_0301, 32'h0000_00A5, JUNK,        0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
    check("load_data held after rw store", bus_if.load_data, 32'hCAFE_F00D);
    do_access("LW mis", 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0101, 32'h0,      JUNK,          0, 4'b0000, 32'h0,        32'h0,        1'b1);
    do_access("SH mis", 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0201, 32'h0,      JUNK,          0, 4'b0000, 32'h0,        32'h0,        1'b1);
    do_access("LH mis", 1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_0203, 32'h0,      JUNK,          0, 4'b0000, 32'h0,        32'h0,        1'b1);
    do_access("LW tmo", 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0040, 32'h0,      JUNK,        255, 4'b0000, 32'h0,        32'h0,        1'b0);
    do_access("LW rec", 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0040, 32'h0,      32'h0BAD_F00D, 0, 4'b0000, 32'h0,        32'h0BAD_F00D, 1'b0);

    // Reset in the second WAIT cycle abandons the access with no strobe.
    @(posedge clk); #1;
    bus_if.mem_read_flag = 1'b1;
    bus_if.mem_sel       = 4'b1111;
    bus_if.mem_addr      = 32'h0000_0080;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    check("pre-reset ram_en", 32'(bus_if.ram_en), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid-wait reset ram_en", 32'(bus_if.ram_en), 32'h0);
    check("mid-wait reset stall", 32'(bus_if.stall_request), 32'h0);
    check("mid-wait reset ram_addr", bus_if.ram_addr, 32'h0);
    check("mid-wait reset load_data", bus_if.load_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_access("SW",   1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, JUNK,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, the maximum number of cycles spent waiting for ram_ready before the access aborts (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port mem_read_flag, input, 1, load request from the decode stage.
REQ-005 SHALL have port mem_write_flag, input, 1, store request from the decode stage.
REQ-006 SHALL have port mem_sign_flag, input, 1, sign-extend load result.
REQ-007 SHALL have port mem_sel, input, 4, access size: 0001 byte, 0011 half, 1111 word.
REQ-008 SHALL have port mem_addr, input, 32, byte address of the access.
REQ-009 SHALL have port mem_write_data, input, 32, store data, right-aligned.
REQ-010 SHALL have port stall_request, output, 1, holds the pipeline while an access is outstanding.
REQ-011 SHALL have port load_data, output, 32, aligned and extended load result.
REQ-012 SHALL have port load_valid, output, 1, one-cycle strobe qualifying load_data.
REQ-013 SHALL have port misaligned_error, output, 1, one-cycle strobe for a misaligned access.
REQ-014 SHALL have port bus_error, output, 1, one-cycle strobe for a ram_ready timeout.
REQ-015 SHALL have ports ram_en (output, 1), ram_write_en (output, 4), ram_addr (output, 32), ram_write_data (output, 32), ram_read_data (input, 32) and ram_ready (input, 1), forming the data-RAM bus.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-017 In IDLE, an accept SHALL occur when (mem_read_flag | mem_write_flag) is set and the access is aligned.
- On accept: latch address, size, sign, direction and data; go to WAIT; stall_request=1 combinationally in the accept cycle.
REQ-018 Misalignment SHALL be defined as a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- Response in IDLE: misaligned_error=1 for that cycle; no bus activity; no stall; state remains IDLE.
REQ-019 If both mem_read_flag and mem_write_flag are set, the access SHALL be performed as a store.
REQ-020 In WAIT, the bus SHALL present stable signals every cycle:
- ram_en=1; ram_addr={addr[31:2],2'b00}.
- ram_write_en=0 for loads; for stores, sel shifted left by addr[1:0].
- ram_write_data: byte replicated x4, half replicated x2, word unchanged.
REQ-021 In WAIT, stall_request SHALL be 1.
- On ram_ready=1: capture ram_read_data; go to DONE.
REQ-022 A WAIT-cycle counter SHALL clear on accept.
- If WAIT_LIMIT WAIT cycles elapse without ram_ready: bus_error=1 in the DONE cycle, captured data forced to 0, go to DONE.
REQ-023 In DONE:
- stall_request=0 and ram_en=0.
- For loads: load_valid=1 and load_data driven.
- Request flags ignored; go to IDLE unconditionally (no re-issue of the same instruction).
REQ-024 Load extraction SHALL use the lane at addr[1:0] (byte) or addr[1] (half).
- Sign-extend if sign flag=1, else zero-extend; word passes through.
REQ-025 Minimum access latency SHALL be 3 cycles: accept, WAIT with ram_ready=1, DONE.
REQ-026 load_data SHALL hold its last value until the next load completes.

Reset
REQ-027 While rst_n=0, the following SHALL hold: state IDLE; counter 0; stall_request, load_valid, misaligned_error, bus_error and ram_en = 0; ram_write_en=0; ram_addr, ram_write_data and load_data = 0.
REQ-028 Reset asserted during WAIT SHALL drop ram_en immediately and abandon the access without any strobe.

Verification
REQ-029 LB, addr 0x103, ram_read_data 0x80AABBCC, ram_ready on first WAIT cycle -> ram_addr 0x100, ram_write_en 0000, load_data 0xFFFFFF80, load_valid in cycle 3; LBU same -> 0x00000080.
REQ-030 SH, addr 0x202, data 0x1234ABCD -> ram_write_en 1100, ram_write_data 0xABCDABCD, stall held until ram_ready, load_valid stays 0.
REQ-031 LW, addr 0x101 -> misaligned_error single pulse, ram_en never 1, stall_request 0.
REQ-032 LW, addr 0x40, ram_ready held 0, WAIT_LIMIT=4 -> 4 WAIT cycles, then bus_error and load_valid pulse, load_data 0, back to IDLE.
REQ-033 rst_n low in 2nd WAIT cycle -> ram_en and stall_request 0 at once; after release, a new SW at 0x10 completes normally with ram_write_en 1111.
